// File: rtl/sort_arb_pkg.sv
// sort_arb_pkg: shared FSM encoding, default sizing and one-hot helper for sort_arbiter.
package sort_arb_pkg;

    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned MAX_REQ            = 8;
    localparam int unsigned MAX_IDX_W          = 3;
    localparam int unsigned STATE_W            = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_ACK   = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

    // Bit 'pos' of the one-hot code for index 'idx'.
    function automatic logic onehot_bit(input logic [MAX_IDX_W-1:0] idx, input int unsigned pos);
        return (32'(idx) == pos);
    endfunction

endpackage

// File: rtl/sort_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; searches from last_winner+1 with wrap.
module rr_pick
    import sort_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        found    = 1'b0;
        cand     = 0;
        pick_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_winner) + i) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    for (genvar j = 0; j < NUM_REQ; j++) begin : g_pick
        assign pick[j] = found && onehot_bit(MAX_IDX_W'(pick_idx), j);
    end

endmodule

// File: rtl/sort_arbiter.sv
// sort_arbiter: round-robin sharing of one sort engine among NUM_REQ requesters.
// Define SORT_ARB_TIMEOUT_EN to add the per-job watchdog with engine abort.
module sort_arbiter
    import sort_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] err,
    output logic               eng_start,
    input  logic               eng_done,
    output logic               eng_rst,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_START = STATE_W'(ST_START);
    localparam logic [STATE_W-1:0] S_RUN   = STATE_W'(ST_RUN);
    localparam logic [STATE_W-1:0] S_ACK   = STATE_W'(ST_ACK);
    localparam logic [STATE_W-1:0] S_ABORT = STATE_W'(ST_ABORT);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 3) begin : g_param_check
        $error("sort_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    logic [STATE_W-1:0] state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, ack_nxt, pick;
    logic [IDX_W-1:0]   last_winner, last_winner_nxt;
    logic [IDX_W-1:0]   win_idx, win_idx_nxt, pick_idx;
    logic               start_nxt;
    logic               done_q, done_rise;

`ifdef SORT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    // Abort lands exactly TIMEOUT_CYCLES cycles after the start pulse.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] err_nxt;
    logic               eng_rst_nxt;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req         (req),
        .last_winner (last_winner),
        .pick        (pick),
        .pick_idx    (pick_idx)
    );

    // Edge, not level: a done left high by the previous job must not finish this one.
    assign done_rise = eng_done & ~done_q;

    always_comb begin
        state_nxt       = state;
        gnt_nxt         = gnt;
        ack_nxt         = '0;
        start_nxt       = 1'b0;
        last_winner_nxt = last_winner;
        win_idx_nxt     = win_idx;
`ifdef SORT_ARB_TIMEOUT_EN
        err_nxt         = '0;
        eng_rst_nxt     = 1'b0;
        cnt_nxt         = cnt;
`endif
        case (state)
            S_IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    state_nxt   = S_START;
                    gnt_nxt     = pick;
                    win_idx_nxt = pick_idx;
                    start_nxt   = 1'b1;
                end
            end
            S_START: begin
                state_nxt = S_RUN;
`ifdef SORT_ARB_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
            end
            S_RUN: begin
                if (done_rise) begin
                    state_nxt = S_ACK;
                    ack_nxt   = gnt;
                end
`ifdef SORT_ARB_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    state_nxt   = S_ABORT;
                    err_nxt     = gnt;
                    eng_rst_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
            S_ACK, S_ABORT: begin
                state_nxt       = S_IDLE;
                gnt_nxt         = '0;
                last_winner_nxt = win_idx;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            gnt         <= '0;
            ack         <= '0;
            eng_start   <= 1'b0;
            busy        <= 1'b0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            win_idx     <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            ack         <= ack_nxt;
            eng_start   <= start_nxt;
            busy        <= (state_nxt != S_IDLE);
            last_winner <= last_winner_nxt;
            win_idx     <= win_idx_nxt;
            done_q      <= eng_done;
        end
    end

`ifdef SORT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            err     <= '0;
            eng_rst <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            err     <= err_nxt;
            eng_rst <= eng_rst_nxt;
        end
    end
`else
    assign err     = '0;
    assign eng_rst = 1'b0;
`endif

endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: randomized jobs against a round-robin reference model with a scoreboard monitor.
// Watchdog scenario runs only when SORT_ARB_TIMEOUT_EN is defined.
module tb_sort_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;
`ifdef SORT_ARB_TIMEOUT_EN
    localparam int LONG_LAT = 12;
`else
    localparam int LONG_LAT = 50;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt, ack, err;
    logic         eng_start, eng_done, eng_rst, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit           is_err;
        logic [N-1:0] vec;
    } exp_t;

    logic [N-1:0] gnt_q[$];
    exp_t         end_q[$];
    int           model_last;
    logic [N-1:0] pending;

    always #5 clk = ~clk;

    sort_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .ack       (ack),
        .err       (err),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .eng_rst   (eng_rst),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got an output event, expected none", name);
    endtask

    // First requester after 'last' in wrap-around order.
    function automatic int rr_model(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int           idx;
            logic [N-1:0] s;
            idx = (last + k) % N;
            s   = r >> idx;
            if (s[0]) return idx;
        end
        return 0;
    endfunction

    // Scoreboard monitor: pops expectations whenever the DUT starts or ends a job.
    initial begin
        exp_t         e;
        logic [N-1:0] g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (eng_start) begin
                    if (gnt_q.size() == 0) note_fail("unexpected_start");
                    else begin
                        g = gnt_q.pop_front();
                        check("grant", 32'(gnt), 32'(g));
                    end
                end
                if ((ack != '0) || (err != '0)) begin
                    if (end_q.size() == 0) note_fail("unexpected_end");
                    else begin
                        e = end_q.pop_front();
                        if (e.is_err) begin
                            check("err_vec", 32'(err), 32'(e.vec));
                            check("eng_rst_pulse", 32'(eng_rst), 32'd1);
                            check("ack_quiet", 32'(ack), 32'd0);
                        end else begin
                            check("ack_vec", 32'(ack), 32'(e.vec));
                            check("err_quiet", 32'({err, eng_rst}), 32'd0);
                            check("gnt_hold_ack", 32'(gnt), 32'(e.vec));
                        end
                    end
                end
            end
        end
    end

    // Runs one job from an IDLE negedge to the next IDLE negedge.
    task automatic run_job(input logic [N-1:0] add, input int lat, input bit stale,
                           input bit drop, input bit rereq, input bit tmo,
                           output logic [N-1:0] gnt_seen);
        logic [N-1:0] w_oh;
        exp_t         e;
        int           w;
        int           n;
        pending = pending | add;
        if (pending == '0) pending = N'(1) << ($urandom % N);
        req  = pending;
        w    = rr_model(pending, model_last);
        w_oh = N'(1) << w;
        gnt_q.push_back(w_oh);
        e.is_err = tmo;
        e.vec    = w_oh;
        end_q.push_back(e);
        @(negedge clk);
        check("start_latency", 32'(eng_start), 32'd1);
        gnt_seen = gnt;
        if (!stale) eng_done = 1'b0;
        if (tmo) begin
            n = 0;
            while (err == '0 && n < 4 * TMO) begin
                @(negedge clk);
                n++;
            end
            check("abort_delay", 32'(n), 32'(TMO));
        end else begin
            if (stale) begin
                repeat (lat) begin
                    @(negedge clk);
                    check("stale_no_ack", 32'(ack), 32'd0);
                end
                eng_done = 1'b0;
                @(negedge clk);
            end else begin
                repeat (lat) begin
                    @(negedge clk);
                    if (drop) begin
                        pending = pending & ~w_oh;
                        req     = pending;
                    end
                end
            end
            eng_done = 1'b1;
            @(negedge clk);
            check("ack_latency", 32'(ack), 32'(w_oh));
        end
        pending    = rereq ? (pending | w_oh) : (pending & ~w_oh);
        req        = pending;
        model_last = w;
        @(negedge clk);
        check("idle_after_job", 32'({busy, gnt}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        logic [N-1:0] gs;
        int           exp_order[5];
        exp_order  = '{0, 1, 2, 3, 0};
        rst        = 1'b1;
        req        = '0;
        eng_done   = 1'b0;
        pending    = '0;
        model_last = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({gnt, ack, err, eng_start, eng_rst, busy}), 32'd0);
        rst = 1'b0;

        run_job(4'b0001, LONG_LAT, 1'b0, 1'b0, 1'b0, 1'b0, gs);
        check("single_gnt", 32'(gs), 32'h1);

        run_job(4'b0010, 6, 1'b1, 1'b0, 1'b0, 1'b0, gs);
        check("stale_gnt", 32'(gs), 32'h2);

        run_job(4'b0100, 4, 1'b0, 1'b1, 1'b0, 1'b0, gs);
        check("drop_gnt", 32'(gs), 32'h4);

        for (int i = 0; i < 40; i++) begin
            run_job(N'($urandom_range(0, 15)), $urandom_range(1, 8),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, gs);
        end

        // Abandon a job mid-RUN with a one-cycle reset.
        pending = pending | 4'b1111;
        req     = pending;
        gnt_q.push_back(N'(1) << rr_model(pending, model_last));
        @(negedge clk);
        check("start_latency", 32'(eng_start), 32'd1);
        eng_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_run", 32'({gnt, ack, err, eng_start, eng_rst, busy}), 32'd0);
        rst        = 1'b0;
        pending    = '0;
        req        = '0;
        model_last = N - 1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({ack, err, busy}), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            run_job(4'b1111, $urandom_range(1, 6), 1'b0, 1'b0, 1'b1, 1'b0, gs);
            check("fair_order", 32'(gs), 32'(N'(1) << exp_order[i]));
        end

`ifdef SORT_ARB_TIMEOUT_EN
        run_job(4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b1, gs);
        check("abort_gnt", 32'(gs), 32'h2);
        run_job(4'b0000, 3, 1'b0, 1'b0, 1'b0, 1'b0, gs);
        check("after_abort_gnt", 32'(gs), 32'h4);
`endif

        pending = '0;
        req     = '0;
        repeat (3) @(negedge clk);
        check("queues_drained", 32'(gnt_q.size() + end_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
